// File: rtl/cim_sequencer.sv
// Command sequencer for the Basic_GeMM_CIM macro: turns core-level write/MAC/read/clear
// commands into registered macro strobes, and streams MAC inputs and readout results.
module cim_sequencer #(
    parameter int NUM_OUT   = 8,
    parameter int ADDR_STEP = 8,
    parameter int GROUP     = 2,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [15:0] cmd_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_idx,
    output logic        busy,
    output logic        done,
    output logic        cim_cs,
    output logic        cim_write,
    output logic        cim_en,
    output logic        cim_partial_sum,
    output logic        cim_reset_output,
    output logic [3:0]  cim_output_reg,
    output logic [31:0] cim_address,
    output logic [31:0] cim_input_data,
    input  logic [31:0] cim_result
);
    typedef enum logic [2:0] {IDLE, WRITE, MAC, RD_WAIT, RD_OUT, CLEAR} state_t;

    localparam logic [1:0]  OP_WRITE   = 2'd0;
    localparam logic [1:0]  OP_MAC     = 2'd1;
    localparam logic [1:0]  OP_READ    = 2'd2;
    localparam logic [3:0]  LAST_IDX   = 4'(NUM_OUT - 1);
    localparam logic [1:0]  LAST_WAIT  = 2'(READ_LAT - 1);
    localparam logic [15:0] LAST_GRP   = 16'(GROUP - 1);
    localparam logic [31:0] STEP       = 32'(ADDR_STEP);
    localparam state_t      READ_FIRST = (READ_LAT == 0) ? RD_OUT : RD_WAIT;

    state_t      state_reg, state_next;
    logic        cs_reg, cs_next;
    logic        write_reg, write_next;
    logic        en_reg, en_next;
    logic        ps_reg, ps_next;
    logic        rstout_reg, rstout_next;
    logic [3:0]  oreg_reg, oreg_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic        in_ready_reg, in_ready_next;
    logic        res_valid_reg, res_valid_next;
    logic [31:0] res_data_reg, res_data_next;
    logic [3:0]  res_idx_reg, res_idx_next;
    logic        done_reg, done_next;
    logic [31:0] word_addr_reg, word_addr_next;
    logic [15:0] remain_reg, remain_next;
    logic [15:0] grp_cnt_reg, grp_cnt_next;
    logic [1:0]  wait_cnt_reg, wait_cnt_next;

    always_comb begin
        state_next     = state_reg;
        cs_next        = 1'b0;
        write_next     = 1'b0;
        en_next        = 1'b0;
        ps_next        = 1'b0;
        rstout_next    = 1'b0;
        oreg_next      = oreg_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        in_ready_next  = 1'b0;
        res_valid_next = 1'b0;
        res_data_next  = res_data_reg;
        res_idx_next   = res_idx_reg;
        done_next      = 1'b0;
        word_addr_next = word_addr_reg;
        remain_next    = remain_reg;
        grp_cnt_next   = grp_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            state_next = WRITE;
                            cs_next    = 1'b1;
                            write_next = 1'b1;
                            addr_next  = cmd_addr;
                            data_next  = cmd_data;
                        end
                        OP_MAC: begin
                            if (cmd_len == 16'd0) begin
                                done_next = 1'b1;
                            end else begin
                                state_next     = MAC;
                                addr_next      = cmd_addr;
                                word_addr_next = cmd_addr;
                                remain_next    = cmd_len;
                                grp_cnt_next   = 16'd0;
                                in_ready_next  = 1'b1;
                            end
                        end
                        OP_READ: begin
                            state_next    = READ_FIRST;
                            cs_next       = 1'b1;
                            en_next       = 1'b1;
                            oreg_next     = 4'd0;
                            wait_cnt_next = 2'd0;
                            if (READ_LAT == 0) begin
                                res_valid_next = 1'b1;
                                res_idx_next   = 4'd0;
                            end
                        end
                        default: begin
                            state_next  = CLEAR;
                            cs_next     = 1'b1;
                            en_next     = 1'b1;
                            rstout_next = 1'b1;
                            oreg_next   = 4'd0;
                        end
                    endcase
                end
            end
            WRITE: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            MAC: begin
                if (in_valid && in_ready_reg) begin
                    cs_next       = 1'b1;
                    en_next       = 1'b1;
                    ps_next       = 1'b1;
                    data_next     = in_data;
                    addr_next     = word_addr_reg;
                    remain_next   = remain_reg - 16'd1;
                    in_ready_next = (remain_reg != 16'd1);
                    if (grp_cnt_reg == LAST_GRP) begin
                        grp_cnt_next   = 16'd0;
                        word_addr_next = word_addr_reg + STEP;
                    end else begin
                        grp_cnt_next = grp_cnt_reg + 16'd1;
                    end
                end else if (!in_ready_reg) begin
                    // last word is on the macro bus this cycle; finish after it
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    in_ready_next = 1'b1;
                end
            end
            RD_WAIT: begin
                cs_next = 1'b1;
                en_next = 1'b1;
                if (wait_cnt_reg == LAST_WAIT) begin
                    state_next     = RD_OUT;
                    res_valid_next = 1'b1;
                    res_data_next  = cim_result;
                    res_idx_next   = oreg_reg;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end
            RD_OUT: begin
                cs_next        = 1'b1;
                en_next        = 1'b1;
                res_valid_next = 1'b1;
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    if (oreg_reg == LAST_IDX) begin
                        state_next = IDLE;
                        cs_next    = 1'b0;
                        en_next    = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next    = READ_FIRST;
                        oreg_next     = oreg_reg + 4'd1;
                        wait_cnt_next = 2'd0;
                        if (READ_LAT == 0) begin
                            res_valid_next = 1'b1;
                            res_idx_next   = oreg_reg + 4'd1;
                        end
                    end
                end
            end
            CLEAR: begin
                if (oreg_reg == LAST_IDX) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cs_next     = 1'b1;
                    en_next     = 1'b1;
                    rstout_next = 1'b1;
                    oreg_next   = oreg_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cs_reg        <= 1'b0;
            write_reg     <= 1'b0;
            en_reg        <= 1'b0;
            ps_reg        <= 1'b0;
            rstout_reg    <= 1'b0;
            oreg_reg      <= 4'd0;
            addr_reg      <= 32'd0;
            data_reg      <= 32'd0;
            in_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= 32'd0;
            res_idx_reg   <= 4'd0;
            done_reg      <= 1'b0;
            word_addr_reg <= 32'd0;
            remain_reg    <= 16'd0;
            grp_cnt_reg   <= 16'd0;
            wait_cnt_reg  <= 2'd0;
        end else begin
            state_reg     <= state_next;
            cs_reg        <= cs_next;
            write_reg     <= write_next;
            en_reg        <= en_next;
            ps_reg        <= ps_next;
            rstout_reg    <= rstout_next;
            oreg_reg      <= oreg_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            in_ready_reg  <= in_ready_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_idx_reg   <= res_idx_next;
            done_reg      <= done_next;
            word_addr_reg <= word_addr_next;
            remain_reg    <= remain_next;
            grp_cnt_reg   <= grp_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    // With zero read latency the held select makes cim_result itself the stable result.
    generate
        if (READ_LAT == 0) begin : g_comb_res
            assign res_data = cim_result;
        end else begin : g_reg_res
            assign res_data = res_data_reg;
        end
    endgenerate

    assign cmd_ready        = (state_reg == IDLE);
    assign busy             = (state_reg != IDLE);
    assign in_ready         = in_ready_reg;
    assign res_valid        = res_valid_reg;
    assign res_idx          = res_idx_reg;
    assign done             = done_reg;
    assign cim_cs           = cs_reg;
    assign cim_write        = write_reg;
    assign cim_en           = en_reg;
    assign cim_partial_sum  = ps_reg;
    assign cim_reset_output = rstout_reg;
    assign cim_output_reg   = oreg_reg;
    assign cim_address      = addr_reg;
    assign cim_input_data   = data_reg;
endmodule

// File: tb/tb_cim_sequencer.sv
// Scoreboard bench for cim_sequencer: stimulus queues expected macro cycles, results and
// done pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_cim_sequencer;
    localparam int NUM_OUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data;
    logic [15:0] cmd_len;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_idx;
    logic        busy, done;
    logic        cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_result;

    cim_sequencer #(.NUM_OUT(8), .ADDR_STEP(8), .GROUP(2), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done),
        .cim_cs(cim_cs), .cim_write(cim_write), .cim_en(cim_en),
        .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
        .cim_output_reg(cim_output_reg), .cim_address(cim_address),
        .cim_input_data(cim_input_data), .cim_result(cim_result)
    );

    always #5 clk = ~clk;

    // Macro output-register model: 0x100+index until cleared, then zero.
    logic [15:0] cleared = 16'd0;
    always @(posedge clk) begin
        if (cim_cs && cim_reset_output) cleared[cim_output_reg] <= 1'b1;
    end
    assign cim_result = cleared[cim_output_reg] ? 32'd0 : (32'h100 + {28'd0, cim_output_reg});

    typedef struct {
        logic        w, e, p, r;
        logic [3:0]  oreg;
        logic [31:0] addr, data;
        logic        chk_ad, chk_oreg;
        int          gap;
    } mev_t;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
    } rev_t;

    mev_t mq[$];
    rev_t rq[$];
    int   exp_done = 0;
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   last_ev = 0;
    logic mon_en = 1'b0;
    logic [31:0] mac_words[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    task automatic push_m(input logic w, input logic e, input logic p, input logic r,
                          input logic [3:0] oreg, input logic [31:0] addr, input logic [31:0] data,
                          input logic chk_ad, input logic chk_oreg, input int gap);
        mev_t m;
        m.w = w; m.e = e; m.p = p; m.r = r; m.oreg = oreg; m.addr = addr; m.data = data;
        m.chk_ad = chk_ad; m.chk_oreg = chk_oreg; m.gap = gap;
        mq.push_back(m);
    endtask

    task automatic push_r(input logic [31:0] data, input logic [3:0] idx);
        rev_t r;
        r.data = data; r.idx = idx;
        rq.push_back(r);
    endtask

    // monitor
    initial begin : monitor
        mev_t m;
        rev_t r;
        logic        have_prev = 1'b0;
        logic [31:0] prev_data = 32'd0;
        logic [3:0]  prev_idx = 4'd0;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            chk("cs_decode", cim_cs, cim_write | cim_en | cim_reset_output);
            chk("oreg_range", cim_output_reg < NUM_OUT, 1);
            if (cmd_ready) chk("idle_quiet", {cim_cs, in_ready, res_valid}, 0);
            if (cim_cs && (cim_write || cim_partial_sum || cim_reset_output)) begin
                chk("macro_expected", mq.size() > 0, 1);
                if (mq.size() > 0) begin
                    m = mq.pop_front();
                    chk("macro_strobes", {cim_write, cim_en, cim_partial_sum, cim_reset_output},
                        {m.w, m.e, m.p, m.r});
                    if (m.chk_ad) begin
                        chk("macro_addr", cim_address, m.addr);
                        chk("macro_data", cim_input_data, m.data);
                    end
                    if (m.chk_oreg) chk("macro_oreg", cim_output_reg, m.oreg);
                    if (m.gap != 0) chk("macro_gap", cyc - last_ev, m.gap);
                end
                last_ev = cyc;
                $display("txn macro w=%b en=%b ps=%b rst=%b oreg=%0d addr=0x%0h data=0x%0h",
                         cim_write, cim_en, cim_partial_sum, cim_reset_output,
                         cim_output_reg, cim_address, cim_input_data);
            end
            if (cim_cs && cim_en && !cim_partial_sum && !cim_reset_output && rq.size() > 0)
                chk("read_sel", cim_output_reg, rq[0].idx);
            if (res_valid && have_prev) begin
                chk("res_hold_data", res_data, prev_data);
                chk("res_hold_idx", res_idx, prev_idx);
            end
            have_prev = res_valid && !res_ready;
            prev_data = res_data;
            prev_idx  = res_idx;
            if (res_valid && res_ready) begin
                chk("res_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("res_data", res_data, r.data);
                    chk("res_idx", res_idx, r.idx);
                end
                $display("txn result idx=%0d data=0x%0h", res_idx, res_data);
            end
            if (done) begin
                chk("done_expected", exp_done > 0, 1);
                if (exp_done > 0) exp_done--;
                $display("txn done");
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [15:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_len = len;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic mac_feed(input int n, input int gap_after, input int gap_len,
                            input logic [31:0] hold_addr);
        for (int i = 0; i < n; i++) begin
            chk("in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = mac_words[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i == gap_after) begin
                for (int b = 0; b < gap_len; b++) begin
                    @(posedge clk); #1;
                    chk("bubble_cs", {cim_cs, cim_en}, 0);
                    chk("bubble_addr", cim_address, hold_addr);
                    chk("bubble_data", cim_input_data, mac_words[i]);
                end
            end
        end
    endtask

    task automatic read_drain(input int stall_idx, input int stall_n);
        int got = 0;
        int stalled = 0;
        int t = 0;
        while (got < NUM_OUT && t < 300) begin
            if (res_valid && res_idx == stall_idx && stalled < stall_n) begin
                res_ready = 1'b0;
                stalled++;
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid && res_ready) got++;
            @(posedge clk); #1;
            t++;
        end
        res_ready = 1'b1;
        chk("read_count", got, NUM_OUT);
    endtask

    task automatic check_after_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output}, 0);
        chk("rst_handshakes", {in_ready, res_valid, done}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] waddr[4];
        logic [31:0] wdata[4];
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 32'd0; cmd_data = 32'd0;
        cmd_len = 16'd0; in_valid = 1'b0; in_data = 32'd0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_after_reset();
        chk("rst_addr", cim_address, 0);
        chk("rst_res", {res_data, res_idx, cim_output_reg}, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // back-to-back writes
        waddr = '{32'd0, 32'd4, 32'd128, 32'd388};
        wdata = '{32'h33221100, 32'h00112233, 32'h77665544, 32'hccddeeff};
        for (int i = 0; i < 4; i++) begin
            push_m(1, 0, 0, 0, 4'd0, waddr[i], wdata[i], 1, 0, (i == 0) ? 0 : 2);
            exp_done++;
            send_cmd(2'd0, waddr[i], wdata[i], 16'd0);
        end
        wait_idle();

        // MAC, continuous input: addresses 0,0,8,8
        mac_words = '{32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        push_m(0, 1, 1, 0, 4'd0, 32'd0, 32'h33333333, 1, 0, 0);
        push_m(0, 1, 1, 0, 4'd0, 32'd0, 32'h44444444, 1, 0, 1);
        push_m(0, 1, 1, 0, 4'd0, 32'd8, 32'h55555555, 1, 0, 1);
        push_m(0, 1, 1, 0, 4'd0, 32'd8, 32'h66666666, 1, 0, 1);
        exp_done++;
        send_cmd(2'd1, 32'd0, 32'd0, 16'd4);
        mac_feed(4, -1, 0, 32'd0);
        wait_idle();

        // MAC len 3 with a 3-cycle bubble after the first word
        mac_words = '{32'ha1a1a1a1, 32'hb2b2b2b2, 32'hc3c3c3c3, 32'h0};
        push_m(0, 1, 1, 0, 4'd0, 32'h40, 32'ha1a1a1a1, 1, 0, 0);
        push_m(0, 1, 1, 0, 4'd0, 32'h40, 32'hb2b2b2b2, 1, 0, 4);
        push_m(0, 1, 1, 0, 4'd0, 32'h48, 32'hc3c3c3c3, 1, 0, 1);
        exp_done++;
        send_cmd(2'd1, 32'h40, 32'd0, 16'd3);
        mac_feed(3, 0, 3, 32'h40);
        wait_idle();

        // MAC len 0: done in the cycle after accept, no macro cycle
        exp_done++;
        send_cmd(2'd1, 32'h1000, 32'd0, 16'd0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_cs", cim_cs, 0);
        chk("len0_addr_held", cim_address, 32'h48);
        wait_idle();

        // READ with a 2-cycle stall at index 3
        for (int i = 0; i < NUM_OUT; i++) push_r(32'h100 + i, 4'(i));
        exp_done++;
        send_cmd(2'd2, 32'd0, 32'd0, 16'd0);
        read_drain(3, 2);
        wait_idle();

        // CLEAR all output registers, then read back zeros
        for (int i = 0; i < NUM_OUT; i++) push_m(0, 1, 0, 1, 4'(i), 32'd0, 32'd0, 0, 1, (i == 0) ? 0 : 1);
        exp_done++;
        send_cmd(2'd3, 32'd0, 32'd0, 16'd0);
        wait_idle();
        for (int i = 0; i < NUM_OUT; i++) push_r(32'd0, 4'(i));
        exp_done++;
        send_cmd(2'd2, 32'd0, 32'd0, 16'd0);
        read_drain(-1, 0);
        wait_idle();

        // reset after 2 of 4 MAC words
        mac_words = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
        push_m(0, 1, 1, 0, 4'd0, 32'h200, 32'h11111111, 1, 0, 0);
        push_m(0, 1, 1, 0, 4'd0, 32'h200, 32'h22222222, 1, 0, 1);
        send_cmd(2'd1, 32'h200, 32'd0, 16'd4);
        mac_feed(2, -1, 0, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_after_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        check_after_reset();

        // reset during a stalled readout
        res_ready = 1'b0;
        send_cmd(2'd2, 32'd0, 32'd0, 16'd0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_res_valid", res_valid, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_after_reset();
        rst = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check_after_reset();

        // a command after reset still works
        push_m(1, 0, 0, 0, 4'd0, 32'h500, 32'hdeadbeef, 1, 0, 0);
        exp_done++;
        send_cmd(2'd0, 32'h500, 32'hdeadbeef, 16'd0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        chk("mq_empty", mq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("done_all_seen", exp_done, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cim_sequencer.md
Name: cim_sequencer

Overview:
- Initiator-side controller for the Basic_GeMM_CIM macro.
- Accepts high-level commands from the core (weight write, MAC burst, output readout, output clear) and generates the macro's cycle-level strobes, address, data and output-register select.
- In MAC bursts, streams input vectors from a valid/ready source; in readout, returns captured results over a valid/ready sink.

Parameters:
- NUM_OUT, 8, number of macro output registers (1..16) read or cleared per command.
- ADDR_STEP, 8, byte increment of cim_address between MAC row groups.
- GROUP, 2, input words issued per address before advancing by ADDR_STEP.
- READ_LAT, 1, cycles from cim_output_reg presented to cim_result valid (0..3).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=WRITE, 1=MAC, 2=READ, 3=CLEAR
- cmd_addr  in  32  WRITE/MAC start byte address
- cmd_data  in  32  WRITE data word
- cmd_len  in  16  MAC input-word count
- in_valid  in  1  MAC input word valid
- in_ready  out  1  MAC input word accepted
- in_data  in  32  MAC input word
- res_valid  out  1  readout result valid
- res_ready  in  1  result accepted
- res_data  out  32  captured cim_result
- res_idx  out  4  output-register index of res_data
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle completion pulse
- cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output  out  1 each  macro cs/write/cim/partial_sum/reset_output
- cim_output_reg  out  4  macro output_reg select
- cim_address  out  32  macro address
- cim_input_data  out  32  macro input_data
- cim_result  in  32  macro cim_output

Behaviour:
- All macro-side outputs are registered.
- Reset values: every output 0, except cmd_ready=1. Reset mid-command returns to IDLE next cycle with all strobes low, abandons the command, and drops any pending result. Macro contents are untouched.
- States: IDLE, WRITE, MAC, RD_WAIT, RD_OUT, CLEAR.
- Accept occurs on cmd_valid&cmd_ready at edge k. Macro activity starts in cycle k+1.
- cim_cs=1 exactly when any of cim_write/cim_en/cim_reset_output is 1.
- WRITE: one cycle with cs=1, write=1, address=cmd_addr, input_data=cmd_data; then IDLE.
- MAC:
  - address starts at cmd_addr. in_ready=1 in MAC.
  - Each cycle with in_valid=1 presents one word: cs=1, en=1, partial_sum=1, input_data=in_data (data appears the cycle after the handshake).
  - Cycles with in_valid=0 are bubbles: strobes low, address and data held.
  - After every GROUP issued words, address += ADDR_STEP (32-bit wrap).
  - After cmd_len words, go to IDLE. cmd_len=0 goes straight to IDLE with done and no macro cycle.
- READ:
  - For i=0..NUM_OUT-1: present en=1, partial_sum=0, output_reg=i, held for the whole of index i.
  - After READ_LAT cycles (RD_WAIT), capture cim_result into res_data, set res_idx=i and res_valid=1 (RD_OUT).
  - Hold res_valid/res_data stable until res_ready. On accept, advance i or go to IDLE after NUM_OUT-1.
  - READ_LAT=0 captures in the same cycle the select is presented.
- CLEAR: for i=0..NUM_OUT-1, one cycle each: cs=1, en=1, reset_output=1, output_reg=i; then IDLE.
- done:
  - Pulses in the first IDLE cycle after a command completes.
  - cmd_ready is 1 in that cycle, so a back-to-back command may be accepted there.
- Idle bus: address/input_data/output_reg hold their last values; strobes 0.
- Only NUM_OUT-1 or lower is ever driven on cim_output_reg.
- in_ready=0 outside MAC. res_valid=0 outside RD_OUT.
- cmd_op is sampled only at accept. Command inputs are ignored while busy.

Test Plan:
- WRITE burst: ops at addr 0,4,128,388 with data 0x33221100, 0x00112233, 0x77665544, 0xccddeeff -> each yields exactly one cs&write cycle with matching address/data, done after each, no gaps beyond one IDLE cycle.
- MAC cmd_addr=0, cmd_len=4, in_data 0x33333333, 0x44444444, 0x55555555, 0x66666666, in_valid continuous -> four en&partial_sum cycles at addresses 0,0,8,8, then done.
- MAC len=3 with in_valid low between words 1 and 2 for 3 cycles -> 3 bubble cycles with strobes low and address held; cmd_len=0 -> done in cycle k+1, no strobes.
- READ with macro model returning 0x100+output_reg, READ_LAT=1, res_ready low for 2 cycles at idx 3 -> res_data 0x100..0x107 in order, idx 3 held stable while stalled, output_reg held.
- CLEAR -> 8 consecutive reset_output cycles, output_reg 0..7, then READ returns model-cleared zeros.
- rst asserted mid-MAC (after 2 of 4 words) and mid-READ stall -> next cycle IDLE, all strobes 0, res_valid 0, cmd_ready 1, no done pulse.
